// File: rtl/counter_updown_mod.sv
// Purpose: modulo-MODULUS up/down counter stage. It can be cascaded through rco_L/enablen
//          and upper_zero, and it supports parallel load with a clamp on out-of-range values.
// Latency: count and done are registered (1 clk). rco_L is combinational from the current state and inputs.
// Backpressure: none. enablen is an active-low count strobe, and rco_L drives the next stage's enablen.
// Ports:
//   clk        - rising-edge clock.
//   rst        - asynchronous active-low reset.
//   enablen    - active-low count enable.
//   load       - synchronous parallel load. It overrides counting.
//   up         - direction select: 1 counts up, 0 counts down.
//   in         - parallel load value. Values >= MODULUS clamp to MODULUS-1.
//   upper_zero - all higher cascaded stages read zero.
//   count      - current count, taken straight from the state register.
//   rco_L      - active-low ripple carry/borrow to the next stage.
//   done       - one-cycle pulse after the whole chain reaches zero while counting down.
module counter_updown_mod #(
  parameter int WIDTH        = 4,
  parameter int MODULUS      = 10,
  parameter bit STOP_AT_ZERO = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enablen,
  input  logic             load,
  input  logic             up,
  input  logic [WIDTH-1:0] in,
  input  logic             upper_zero,
  output logic [WIDTH-1:0] count,
  output logic             rco_L,
  output logic             done
);

  // Comparisons against MODULUS use WIDTH+1 bits so that MODULUS == 2**WIDTH is representable.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             done_q, done_d;

  logic out_of_range;
  logic at_max;
  logic at_zero;
  logic hold_zero;
  logic in_range;
  logic count_en;

  // A value at or above MODULUS is treated as terminal in both directions.
  // The next enabled edge therefore lands on a legal value.
  assign out_of_range = ({1'b0, count_q} >= MOD_EXT);
  assign at_max       = (count_q == MAX_VAL) || out_of_range;
  assign at_zero      = (count_q == '0);
  assign hold_zero    = STOP_AT_ZERO && upper_zero;
  assign in_range     = ({1'b0, in} < MOD_EXT);
  assign count_en     = !enablen;

  // The borrow is suppressed at zero when the whole chain is parked there.
  // This stops higher stages from wrapping underneath a stopped chain.
  assign rco_L = !(count_en &&
                   (up ? at_max : ((at_zero && !hold_zero) || out_of_range)));

  always_comb begin
    count_d = count_q;
    done_d  = 1'b0;
    if (load) begin
      count_d = in_range ? in : MAX_VAL;
    end else if (count_en) begin
      if (up) begin
        count_d = at_max ? '0 : count_q + ONE;
      end else if (out_of_range) begin
        count_d = MAX_VAL;
      end else if (at_zero) begin
        count_d = hold_zero ? '0 : MAX_VAL;
      end else begin
        count_d = count_q - ONE;
        // A 1->0 step with all higher stages at zero means the chain just expired.
        done_d  = upper_zero && (count_q == ONE);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign count = count_q;
  assign done  = done_q;

endmodule

// File: tb/tb_counter_updown_mod.sv
module tb_counter_updown_mod;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Instance A: WIDTH=4, MODULUS=10, STOP_AT_ZERO=1
  logic       a_en_n, a_load, a_up, a_uz;
  logic [3:0] a_in, a_count;
  logic       a_rco, a_done;

  // Instance B: MODULUS=6
  logic       b_en_n, b_load, b_up, b_uz;
  logic [3:0] b_in, b_count;
  logic       b_rco, b_done;

  // Cascade: lo (units) feeds hi (tens)
  logic       c_en_n, c_load, c_up;
  logic [3:0] lo_in, hi_in, lo_count, hi_count;
  logic       lo_rco, hi_rco, lo_done, hi_done;
  logic       lo_uz;
  logic       hi_uz;
  assign lo_uz = (hi_count == 4'd0);
  assign hi_uz = 1'b1;

  counter_updown_mod #(.WIDTH(4), .MODULUS(10), .STOP_AT_ZERO(1'b1)) u_a (
    .clk(clk), .rst(rst), .enablen(a_en_n), .load(a_load), .up(a_up), .in(a_in),
    .upper_zero(a_uz), .count(a_count), .rco_L(a_rco), .done(a_done));

  counter_updown_mod #(.WIDTH(4), .MODULUS(6), .STOP_AT_ZERO(1'b1)) u_b (
    .clk(clk), .rst(rst), .enablen(b_en_n), .load(b_load), .up(b_up), .in(b_in),
    .upper_zero(b_uz), .count(b_count), .rco_L(b_rco), .done(b_done));

  counter_updown_mod #(.WIDTH(4), .MODULUS(10), .STOP_AT_ZERO(1'b1)) u_lo (
    .clk(clk), .rst(rst), .enablen(c_en_n), .load(c_load), .up(c_up), .in(lo_in),
    .upper_zero(lo_uz), .count(lo_count), .rco_L(lo_rco), .done(lo_done));

  counter_updown_mod #(.WIDTH(4), .MODULUS(10), .STOP_AT_ZERO(1'b1)) u_hi (
    .clk(clk), .rst(rst), .enablen(lo_rco), .load(c_load), .up(c_up), .in(hi_in),
    .upper_zero(hi_uz), .count(hi_count), .rco_L(hi_rco), .done(hi_done));

  typedef struct packed {
    logic [3:0] cnt;
    logic       rco;
    logic       done;
  } obs_t;

  typedef struct packed {
    logic [3:0] hi;
    logic [3:0] lo;
    logic       done;
  } ch_t;

  obs_t sb_q[$];
  ch_t  ch_q[$];
  obs_t got, exp_v;
  ch_t  cgot, cexp;
  int   checks   = 0;
  int   failures = 0;

  task automatic apply_a(input logic en_n, input logic ld, input logic u,
                         input logic uz, input logic [3:0] din);
    a_en_n = en_n; a_load = ld; a_up = u; a_uz = uz; a_in = din;
    @(posedge clk); #1;
  endtask

  task automatic apply_b(input logic en_n, input logic ld, input logic u,
                         input logic [3:0] din);
    b_en_n = en_n; b_load = ld; b_up = u; b_uz = 1'b0; b_in = din;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    a_en_n = 1'b1; a_load = 1'b0; a_up = 1'b0; a_uz = 1'b0; a_in = 4'd0;
    b_en_n = 1'b1; b_load = 1'b0; b_up = 1'b0; b_uz = 1'b0; b_in = 4'd0;
    c_en_n = 1'b1; c_load = 1'b0; c_up = 1'b0; lo_in = 4'd0; hi_in = 4'd0;
    #2;
    sb_q.push_back({4'd0, 1'b1, 1'b0});
    got = {a_count, a_rco, a_done}; exp_v = sb_q.pop_front(); checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL reset_state: got cnt=%0d rco_L=%b done=%b, expected cnt=%0d rco_L=%b done=%b",
               got.cnt, got.rco, got.done, exp_v.cnt, exp_v.rco, exp_v.done);
    end
    // Count 0 with down-count enabled and upper_zero=0 is terminal, so rco_L must go low.
    a_en_n = 1'b0;
    #1;
    sb_q.push_back({4'd0, 1'b0, 1'b0});
    got = {a_count, a_rco, a_done}; exp_v = sb_q.pop_front(); checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL reset_rco: got cnt=%0d rco_L=%b done=%b, expected cnt=%0d rco_L=%b done=%b",
               got.cnt, got.rco, got.done, exp_v.cnt, exp_v.rco, exp_v.done);
    end
    // While reset is held, load must be ignored.
    sb_q.push_back({4'd0, 1'b1, 1'b0});
    apply_a(1'b1, 1'b1, 1'b0, 1'b0, 4'd5);
    got = {a_count, a_rco, a_done}; exp_v = sb_q.pop_front(); checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL reset_ignores_load: got cnt=%0d rco_L=%b done=%b, expected cnt=%0d rco_L=%b done=%b",
               got.cnt, got.rco, got.done, exp_v.cnt, exp_v.rco, exp_v.done);
    end
    checks++;
    if (b_count !== 4'd0 || lo_count !== 4'd0 || hi_count !== 4'd0) begin
      failures++;
      $display("FAIL reset_others: b=%0d lo=%0d hi=%0d, expected all 0", b_count, lo_count, hi_count);
    end
    a_load = 1'b0;
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_down_wrap();
    logic [3:0] cnt_t[5] = '{4'd2, 4'd1, 4'd0, 4'd9, 4'd8};
    logic       rco_t[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    sb_q.push_back({4'd3, 1'b1, 1'b0});
    apply_a(1'b1, 1'b1, 1'b0, 1'b0, 4'd3);
    got = {a_count, a_rco, a_done}; exp_v = sb_q.pop_front(); checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL down_wrap_load: got cnt=%0d rco_L=%b done=%b, expected cnt=%0d rco_L=%b done=%b",
               got.cnt, got.rco, got.done, exp_v.cnt, exp_v.rco, exp_v.done);
    end
    for (int i = 0; i < 5; i++) begin
      sb_q.push_back({cnt_t[i], rco_t[i], 1'b0});
      apply_a(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      got = {a_count, a_rco, a_done}; exp_v = sb_q.pop_front(); checks++;
      if (got !== exp_v) begin
        failures++;
        $display("FAIL down_wrap step %0d: got cnt=%0d rco_L=%b done=%b, expected cnt=%0d rco_L=%b done=%b",
                 i, got.cnt, got.rco, got.done, exp_v.cnt, exp_v.rco, exp_v.done);
      end
    end
  endtask

  task automatic test_stop_at_zero();
    logic [3:0] cnt_t[4]  = '{4'd1, 4'd0, 4'd0, 4'd0};
    logic       done_t[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    sb_q.push_back({4'd2, 1'b1, 1'b0});
    apply_a(1'b1, 1'b1, 1'b0, 1'b1, 4'd2);
    got = {a_count, a_rco, a_done}; exp_v = sb_q.pop_front(); checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL stop_zero_load: got cnt=%0d rco_L=%b done=%b, expected cnt=%0d rco_L=%b done=%b",
               got.cnt, got.rco, got.done, exp_v.cnt, exp_v.rco, exp_v.done);
    end
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back({cnt_t[i], 1'b1, done_t[i]});
      apply_a(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
      got = {a_count, a_rco, a_done}; exp_v = sb_q.pop_front(); checks++;
      if (got !== exp_v) begin
        failures++;
        $display("FAIL stop_zero step %0d: got cnt=%0d rco_L=%b done=%b, expected cnt=%0d rco_L=%b done=%b",
                 i, got.cnt, got.rco, got.done, exp_v.cnt, exp_v.rco, exp_v.done);
      end
    end
    // A load from 1 down to 0 must not raise done.
    sb_q.push_back({4'd1, 1'b1, 1'b0});
    sb_q.push_back({4'd0, 1'b1, 1'b0});
    for (int i = 0; i < 2; i++) begin
      apply_a(i == 0 ? 1'b1 : 1'b0, 1'b1, 1'b0, 1'b1, i == 0 ? 4'd1 : 4'd0);
      got = {a_count, a_rco, a_done}; exp_v = sb_q.pop_front(); checks++;
      if (got !== exp_v) begin
        failures++;
        $display("FAIL load_zero_no_done %0d: got cnt=%0d rco_L=%b done=%b, expected cnt=%0d rco_L=%b done=%b",
                 i, got.cnt, got.rco, got.done, exp_v.cnt, exp_v.rco, exp_v.done);
      end
    end
  endtask

  task automatic test_up_wrap_mod6();
    logic [3:0] cnt_t[3] = '{4'd5, 4'd0, 4'd1};
    logic       rco_t[3] = '{1'b0, 1'b1, 1'b1};
    sb_q.push_back({4'd4, 1'b1, 1'b0});
    apply_b(1'b1, 1'b1, 1'b1, 4'd4);
    got = {b_count, b_rco, b_done}; exp_v = sb_q.pop_front(); checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL up6_load: got cnt=%0d rco_L=%b done=%b, expected cnt=%0d rco_L=%b done=%b",
               got.cnt, got.rco, got.done, exp_v.cnt, exp_v.rco, exp_v.done);
    end
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back({cnt_t[i], rco_t[i], 1'b0});
      apply_b(1'b0, 1'b0, 1'b1, 4'd0);
      got = {b_count, b_rco, b_done}; exp_v = sb_q.pop_front(); checks++;
      if (got !== exp_v) begin
        failures++;
        $display("FAIL up6 step %0d: got cnt=%0d rco_L=%b done=%b, expected cnt=%0d rco_L=%b done=%b",
                 i, got.cnt, got.rco, got.done, exp_v.cnt, exp_v.rco, exp_v.done);
      end
    end
    // Load 7 clamps to 5 with enablen=1, so rco_L stays high. Enabling alone then drops rco_L.
    sb_q.push_back({4'd5, 1'b1, 1'b0});
    apply_b(1'b1, 1'b1, 1'b1, 4'd7);
    got = {b_count, b_rco, b_done}; exp_v = sb_q.pop_front(); checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL up6_clamp_disabled: got cnt=%0d rco_L=%b done=%b, expected cnt=%0d rco_L=%b done=%b",
               got.cnt, got.rco, got.done, exp_v.cnt, exp_v.rco, exp_v.done);
    end
    sb_q.push_back({4'd5, 1'b0, 1'b0});
    b_load = 1'b0; b_en_n = 1'b0;
    #1;
    got = {b_count, b_rco, b_done}; exp_v = sb_q.pop_front(); checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL up6_rco_comb: got cnt=%0d rco_L=%b done=%b, expected cnt=%0d rco_L=%b done=%b",
               got.cnt, got.rco, got.done, exp_v.cnt, exp_v.rco, exp_v.done);
    end
    b_en_n = 1'b1;
  endtask

  task automatic test_load_priority();
    logic [3:0] cnt_t[5] = '{4'd9, 4'd4, 4'd4, 4'd9, 4'd0};
    logic       rco_t[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic       en_t[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       ld_t[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [3:0] in_t[5]  = '{4'd12, 4'd4, 4'd0, 4'd9, 4'd0};
    for (int i = 0; i < 5; i++) begin
      sb_q.push_back({cnt_t[i], rco_t[i], 1'b0});
      apply_a(en_t[i], ld_t[i], 1'b1, 1'b0, in_t[i]);
      got = {a_count, a_rco, a_done}; exp_v = sb_q.pop_front(); checks++;
      if (got !== exp_v) begin
        failures++;
        $display("FAIL load_prio step %0d: got cnt=%0d rco_L=%b done=%b, expected cnt=%0d rco_L=%b done=%b",
                 i, got.cnt, got.rco, got.done, exp_v.cnt, exp_v.rco, exp_v.done);
      end
    end
  endtask

  task automatic test_cascade();
    int pulses = 0;
    int v;
    c_up = 1'b0; c_en_n = 1'b1; c_load = 1'b1; lo_in = 4'd0; hi_in = 4'd2;
    ch_q.push_back({4'd2, 4'd0, 1'b0});
    @(posedge clk); #1;
    cgot = {hi_count, lo_count, lo_done}; cexp = ch_q.pop_front(); checks++;
    if (cgot !== cexp) begin
      failures++;
      $display("FAIL cascade_load: got %0d%0d done=%b, expected %0d%0d done=%b",
               cgot.hi, cgot.lo, cgot.done, cexp.hi, cexp.lo, cexp.done);
    end
    c_load = 1'b0; c_en_n = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      v = (k <= 20) ? 20 - k : 0;
      ch_q.push_back({4'(v / 10), 4'(v % 10), (k == 20)});
      @(posedge clk); #1;
      if (lo_done === 1'b1) pulses++;
      cgot = {hi_count, lo_count, lo_done}; cexp = ch_q.pop_front(); checks++;
      if (cgot !== cexp) begin
        failures++;
        $display("FAIL cascade step %0d: got %0d%0d done=%b, expected %0d%0d done=%b",
                 k, cgot.hi, cgot.lo, cgot.done, cexp.hi, cexp.lo, cexp.done);
      end
    end
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("FAIL cascade_done_count: got %0d pulses, expected 1", pulses);
    end
    c_en_n = 1'b1;
  endtask

  task automatic test_async_reset();
    sb_q.push_back({4'd7, 1'b1, 1'b0});
    apply_a(1'b1, 1'b1, 1'b0, 1'b0, 4'd7);
    got = {a_count, a_rco, a_done}; exp_v = sb_q.pop_front(); checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL areset_load7: got cnt=%0d rco_L=%b done=%b, expected cnt=%0d rco_L=%b done=%b",
               got.cnt, got.rco, got.done, exp_v.cnt, exp_v.rco, exp_v.done);
    end
    // Assert reset mid-cycle, well before the next rising edge.
    a_load = 1'b0;
    #2 rst = 1'b0;
    #1;
    sb_q.push_back({4'd0, 1'b1, 1'b0});
    got = {a_count, a_rco, a_done}; exp_v = sb_q.pop_front(); checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL areset_immediate: got cnt=%0d rco_L=%b done=%b, expected cnt=%0d rco_L=%b done=%b",
               got.cnt, got.rco, got.done, exp_v.cnt, exp_v.rco, exp_v.done);
    end
    sb_q.push_back({4'd0, 1'b1, 1'b0});
    apply_a(1'b1, 1'b1, 1'b0, 1'b0, 4'd5);
    got = {a_count, a_rco, a_done}; exp_v = sb_q.pop_front(); checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL areset_held_load: got cnt=%0d rco_L=%b done=%b, expected cnt=%0d rco_L=%b done=%b",
               got.cnt, got.rco, got.done, exp_v.cnt, exp_v.rco, exp_v.done);
    end
    @(negedge clk); rst = 1'b1;
    sb_q.push_back({4'd5, 1'b1, 1'b0});
    @(posedge clk); #1;
    got = {a_count, a_rco, a_done}; exp_v = sb_q.pop_front(); checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL areset_first_edge: got cnt=%0d rco_L=%b done=%b, expected cnt=%0d rco_L=%b done=%b",
               got.cnt, got.rco, got.done, exp_v.cnt, exp_v.rco, exp_v.done);
    end
    a_load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_down_wrap();
    test_stop_at_zero();
    test_up_wrap_mod6();
    test_load_priority();
    test_cascade();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
